hazard_control_unit: RTL and testbench

- Produces the mux select lines consumed by the decode stage: select_ir3, select_pc3, select_x3, select_y3, select_md3.
- Also produces the fetch-stage freeze signal.
- Inspects the IR of decode (ir2), execute (ir3), memory (ir4) and writeback (ir5) and tracks bubble/flush sequences in a small state machine.
- Detects RAW hazards, forwards writeback data (z5), squashes wrong-path instructions after taken branches, and freezes the pipeline on external hold.

---
 rtl/hazard_control_unit_if.sv | 42 ++++
 rtl/hazard_control_unit.sv | 183 ++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit_if
//  Description : Bundle between the pipeline datapath and the hazard control
//                unit: stage instruction registers and control inputs in,
//                decode-stage mux selects, fetch freeze and bubble count out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_control_unit_if #(
    parameter int PERF_W = 16
);
    logic [31:0]       ir2_output;
    logic [31:0]       ir3_output;
    logic [31:0]       ir4_output;
    logic [31:0]       ir5_output;
    logic              branch_taken;
    logic              hold;
    logic [1:0]        select_ir3;
    logic              select_pc3;
    logic [1:0]        select_x3;
    logic [1:0]        select_y3;
    logic [1:0]        select_md3;
    logic              stall_fetch;
    logic [PERF_W-1:0] bubble_count;

    // Datapath side: supplies instructions and control, consumes selects
    modport master (
        output ir2_output, ir3_output, ir4_output, ir5_output,
        output branch_taken, hold,
        input  select_ir3, select_pc3, select_x3, select_y3, select_md3,
        input  stall_fetch, bubble_count
    );

    // Hazard unit side
    modport slave (
        input  ir2_output, ir3_output, ir4_output, ir5_output,
        input  branch_taken, hold,
        output select_ir3, select_pc3, select_x3, select_y3, select_md3,
        output stall_fetch, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit
//  Description : Decode-stage mux select generation for a 5-stage RV32I pipe.
//                RAW hazard detection against ir3/ir4/ir5, bubble insertion,
//                wrong-path flush after taken branches, external hold freeze
//                and a saturating bubble counter.
//                Optional macro HAZ_FORWARD_EN: forward z5 from writeback
//                instead of stalling for writeback-stage dependencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    hazard_control_unit_if.slave bus
);
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [1:0] c_flush_init = 2'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic f_writes_rd(input logic [31:0] ir);
        case (ir[6:0])
            c_op_lui, c_op_auipc, c_op_jal, c_op_jalr,
            c_op_load, c_op_imm, c_op_reg: f_writes_rd = (ir[11:7] != 5'd0);
            default:                       f_writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic f_uses_rs1(input logic [31:0] ir);
        f_uses_rs1 = !(ir[6:0] == c_op_lui || ir[6:0] == c_op_auipc ||
                       ir[6:0] == c_op_jal);
    endfunction

    function automatic logic f_uses_rs2(input logic [31:0] ir);
        f_uses_rs2 = (ir[6:0] == c_op_reg || ir[6:0] == c_op_branch ||
                      ir[6:0] == c_op_store);
    endfunction

    // True when producer ir_p writes a register that consumer ir_c reads
    function automatic logic f_match(input logic [31:0] ir_p, input logic [31:0] ir_c);
        f_match = f_writes_rd(ir_p) &&
                  ((f_uses_rs1(ir_c) && ir_p[11:7] == ir_c[19:15]) ||
                   (f_uses_rs2(ir_c) && ir_p[11:7] == ir_c[24:20]));
    endfunction

    state_t            r_state, w_state_next;
    logic [1:0]        r_cnt, w_cnt_next;
    logic [PERF_W-1:0] r_bubble_count;

    logic [1:0] w_sel_ir3, w_sel_x3, w_sel_y3, w_sel_md3;
    logic       w_sel_pc3, w_stall_fetch;
    logic [1:0] w_need;
    logic [1:0] w_base_x3, w_base_y3;
    logic       w_hit3, w_hit4;

    assign w_hit3 = f_match(bus.ir3_output, bus.ir2_output);
    assign w_hit4 = f_match(bus.ir4_output, bus.ir2_output);

    assign w_base_x3 = (bus.ir2_output[6:0] == c_op_auipc ||
                        bus.ir2_output[6:0] == c_op_jal) ? 2'd1 : 2'd0;
    assign w_base_y3 = (bus.ir2_output[6:0] == c_op_reg ||
                        bus.ir2_output[6:0] == c_op_branch) ? 2'd0 : 2'd1;

`ifdef HAZ_FORWARD_EN
    // Writeback dependencies are served by the z5 forward path
    logic w_fwd_rs1, w_fwd_rs2;
    assign w_fwd_rs1 = f_writes_rd(bus.ir5_output) && f_uses_rs1(bus.ir2_output) &&
                       (bus.ir5_output[11:7] == bus.ir2_output[19:15]);
    assign w_fwd_rs2 = f_writes_rd(bus.ir5_output) && f_uses_rs2(bus.ir2_output) &&
                       (bus.ir5_output[11:7] == bus.ir2_output[24:20]);
    assign w_need = w_hit3 ? 2'd2 : (w_hit4 ? 2'd1 : 2'd0);
`else
    // Without forwarding the consumer waits until the producer has retired
    logic w_hit5;
    assign w_hit5 = f_match(bus.ir5_output, bus.ir2_output);
    assign w_need = w_hit3 ? 2'd3 : (w_hit4 ? 2'd2 : (w_hit5 ? 2'd1 : 2'd0));
`endif

    // Next-state and select generation; priority reset > hold > branch > hazard
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_sel_ir3     = 2'd0;
        w_sel_pc3     = 1'b0;
        w_sel_x3      = w_base_x3;
        w_sel_y3      = w_base_y3;
        w_sel_md3     = 2'd0;
        w_stall_fetch = 1'b0;
        if (reset) begin
            w_sel_ir3     = 2'd1;
            w_sel_x3      = 2'd0;
            w_sel_y3      = 2'd0;
            w_stall_fetch = 1'b1;
            w_state_next  = RUN;
            w_cnt_next    = 2'd0;
        end else if (bus.hold) begin
            w_sel_ir3     = 2'd2;
            w_sel_pc3     = 1'b1;
            w_sel_x3      = 2'd2;
            w_sel_y3      = 2'd2;
            w_sel_md3     = 2'd2;
            w_stall_fetch = 1'b1;
        end else if (bus.branch_taken) begin
            // Bubble carries nop (addi x0,x0,0) base selects
            w_sel_ir3    = 2'd1;
            w_sel_x3     = 2'd0;
            w_sel_y3     = 2'd1;
            w_cnt_next   = c_flush_init;
            w_state_next = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_need != 2'd0) begin
                        w_sel_ir3     = 2'd1;
                        w_sel_x3      = 2'd0;
                        w_sel_y3      = 2'd1;
                        w_stall_fetch = 1'b1;
                        w_cnt_next    = w_need - 2'd1;
                        w_state_next  = (w_need > 2'd1) ? STALL : RUN;
                    end else begin
`ifdef HAZ_FORWARD_EN
                        if (w_fwd_rs1) w_sel_x3 = 2'd3;
                        if (w_fwd_rs2 && w_base_y3 == 2'd0) w_sel_y3 = 2'd3;
                        if (w_fwd_rs2 && bus.ir2_output[6:0] == c_op_store) w_sel_md3 = 2'd1;
`endif
                    end
                end
                STALL, FLUSH: begin
                    // r_cnt counts the bubbles still owed, this one included
                    w_sel_ir3     = 2'd1;
                    w_sel_x3      = 2'd0;
                    w_sel_y3      = 2'd1;
                    w_stall_fetch = (r_state == STALL);
                    w_cnt_next    = (r_cnt == 2'd0) ? 2'd0 : r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) w_state_next = RUN;
                end
                default: begin
                    w_state_next = RUN;
                    w_cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // State, remaining-bubble count and saturating performance counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RUN;
            r_cnt          <= 2'd0;
            r_bubble_count <= '0;
        end else if (!bus.hold) begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_sel_ir3 == 2'd1 && r_bubble_count != {PERF_W{1'b1}})
                r_bubble_count <= r_bubble_count + 1'b1;
        end
    end

    assign bus.select_ir3   = w_sel_ir3;
    assign bus.select_pc3   = w_sel_pc3;
    assign bus.select_x3    = w_sel_x3;
    assign bus.select_y3    = w_sel_y3;
    assign bus.select_md3   = w_sel_md3;
    assign bus.stall_fetch  = w_stall_fetch;
    assign bus.bubble_count = r_bubble_count;
endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_control_unit
//  Description : Directed vector table plus multi-cycle sequences for the
//                hazard control unit (FLUSH_CYCLES=2, PERF_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;
    localparam int PERF_W = 4;
`ifdef HAZ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] ADDI_X1  = 32'h00500093;
    localparam logic [31:0] ADDI_X0  = 32'h00500013;
    localparam logic [31:0] ADD_X2   = 32'h00108133;
    localparam logic [31:0] SW_X1    = 32'h00112023;
    localparam logic [31:0] AUIPC_X5 = 32'h00000297;
    localparam logic [31:0] JAL_X1   = 32'h000000EF;
    localparam logic [31:0] BEQ_X1X2 = 32'h00208063;
    localparam logic [31:0] LW_X4    = 32'h0000A203;
    localparam logic [31:0] ADD_X6   = 32'h00310333;
    localparam logic [31:0] LUI_X3   = 32'h000011B7;
    localparam logic [31:0] LUI_RS1  = 32'h000081B7;
    localparam logic [31:0] ADDI_X7  = 32'h00100393;

    // {select_ir3, select_pc3, select_x3, select_y3, select_md3, stall_fetch}
    function automatic logic [9:0] pk(input logic [1:0] a, input logic b,
                                      input logic [1:0] c, input logic [1:0] d,
                                      input logic [1:0] e, input logic f);
        return {a, b, c, d, e, f};
    endfunction

    localparam logic [9:0] BUB   = 10'b01_0_00_01_00_1;
    localparam logic [9:0] FLB   = 10'b01_0_00_01_00_0;
    localparam logic [9:0] HOLDV = 10'b10_1_10_10_10_1;
    localparam logic [9:0] RSTV  = 10'b01_0_00_00_00_1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.PERF_W(PERF_W)) bus ();
    hazard_control_unit #(.FLUSH_CYCLES(2), .PERF_W(PERF_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] ir2, ir3, ir4, ir5;
        logic        br, hd;
        logic [9:0]  exp;
    } vec_t;
    vec_t vt[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] i2, input logic [31:0] i3,
                          input logic [31:0] i4, input logic [31:0] i5);
        bus.ir2_output = i2;
        bus.ir3_output = i3;
        bus.ir4_output = i4;
        bus.ir5_output = i5;
    endtask

    task automatic chk_sel(input string name, input logic [9:0] exp);
        logic [9:0] got;
        #1;
        got = {bus.select_ir3, bus.select_pc3, bus.select_x3, bus.select_y3,
               bus.select_md3, bus.stall_fetch};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got ir3=%0d pc3=%0d x3=%0d y3=%0d md3=%0d stall=%0d, expected ir3=%0d pc3=%0d x3=%0d y3=%0d md3=%0d stall=%0d",
                     name, got[9:8], got[7], got[6:5], got[4:3], got[2:1], got[0],
                     exp[9:8], exp[7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic chk_cnt(input string name, input int exp);
        checks++;
        if (int'(bus.bubble_count) !== exp) begin
            errors++;
            $display("FAIL %s: bubble_count got %0d expected %0d", name, bus.bubble_count, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.branch_taken = 1'b0;
        bus.hold = 1'b0;
        set_ir(NOP, NOP, NOP, NOP);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        reset = 1'b1;
        bus.branch_taken = 1'b0;
        bus.hold = 1'b0;
        set_ir(AUIPC_X5, NOP, NOP, NOP);

        // Reset-cycle outputs and cleared counter
        chk_sel("reset_outputs", RSTV);
        tick();
        reset = 1'b0;
        set_ir(NOP, NOP, NOP, NOP);
        chk_cnt("reset_count", 0);

        // Single-cycle vectors, each applied from a freshly reset RUN state
        vt.push_back('{NOP,      NOP,     NOP,     NOP,     1'b0, 1'b0, pk(0,0,0,1,0,0)});
        vt.push_back('{ADD_X2,   NOP,     NOP,     NOP,     1'b0, 1'b0, pk(0,0,0,0,0,0)});
        vt.push_back('{AUIPC_X5, NOP,     NOP,     NOP,     1'b0, 1'b0, pk(0,0,1,1,0,0)});
        vt.push_back('{JAL_X1,   NOP,     NOP,     NOP,     1'b0, 1'b0, pk(0,0,1,1,0,0)});
        vt.push_back('{BEQ_X1X2, NOP,     NOP,     NOP,     1'b0, 1'b0, pk(0,0,0,0,0,0)});
        vt.push_back('{SW_X1,    NOP,     NOP,     NOP,     1'b0, 1'b0, pk(0,0,0,1,0,0)});
        vt.push_back('{ADDI_X7,  ADDI_X0, NOP,     NOP,     1'b0, 1'b0, pk(0,0,0,1,0,0)});
        vt.push_back('{ADDI_X7,  ADDI_X1, NOP,     NOP,     1'b0, 1'b0, pk(0,0,0,1,0,0)});
        vt.push_back('{LUI_RS1,  ADDI_X1, NOP,     NOP,     1'b0, 1'b0, pk(0,0,0,1,0,0)});
        vt.push_back('{ADD_X2,   NOP,     NOP,     ADDI_X1, 1'b0, 1'b0, FWD ? pk(0,0,3,3,0,0) : BUB});
        vt.push_back('{SW_X1,    NOP,     NOP,     ADDI_X1, 1'b0, 1'b0, FWD ? pk(0,0,0,1,1,0) : BUB});
        vt.push_back('{ADD_X6,   NOP,     NOP,     LUI_X3,  1'b0, 1'b0, FWD ? pk(0,0,0,3,0,0) : BUB});
        vt.push_back('{BEQ_X1X2, NOP,     NOP,     ADD_X2,  1'b0, 1'b0, FWD ? pk(0,0,0,3,0,0) : BUB});
        vt.push_back('{ADD_X2,   NOP,     ADDI_X1, NOP,     1'b0, 1'b0, BUB});
        vt.push_back('{ADD_X2,   NOP,     ADDI_X1, ADDI_X1, 1'b0, 1'b0, BUB});
        vt.push_back('{LW_X4,    JAL_X1,  NOP,     NOP,     1'b0, 1'b0, BUB});
        vt.push_back('{NOP,      NOP,     NOP,     NOP,     1'b1, 1'b0, FLB});
        vt.push_back('{ADD_X2,   ADDI_X1, NOP,     NOP,     1'b1, 1'b0, FLB});
        vt.push_back('{ADD_X2,   ADDI_X1, NOP,     NOP,     1'b1, 1'b1, HOLDV});
        vt.push_back('{AUIPC_X5, NOP,     NOP,     NOP,     1'b0, 1'b1, HOLDV});

        for (int i = 0; i < vt.size(); i++) begin
            do_reset();
            set_ir(vt[i].ir2, vt[i].ir3, vt[i].ir4, vt[i].ir5);
            bus.branch_taken = vt[i].br;
            bus.hold = vt[i].hd;
            chk_sel($sformatf("vec%0d", i), vt[i].exp);
        end

        // RAW on ir3 with the pipeline advancing behind the bubbles
        do_reset();
        set_ir(ADD_X2, ADDI_X1, NOP, NOP);
        nb = FWD ? 2 : 3;
        for (int c = 0; c < nb; c++) begin
            chk_sel($sformatf("raw_bubble%0d", c), BUB);
            tick();
            set_ir(ADD_X2, NOP, bus.ir3_output, bus.ir4_output);
        end
        chk_sel("raw_release", FWD ? pk(0,0,3,3,0,0) : pk(0,0,0,0,0,0));
        chk_cnt("raw_count", nb);

        // Branch flush: two bubbles, no fetch stall, hazards ignored
        do_reset();
        bus.branch_taken = 1'b1;
        chk_sel("flush_first", FLB);
        tick();
        bus.branch_taken = 1'b0;
        set_ir(ADD_X2, ADDI_X1, NOP, NOP);
        chk_sel("flush_second_ignores_hazard", FLB);
        tick();
        set_ir(NOP, NOP, NOP, NOP);
        chk_sel("flush_done", pk(0,0,0,1,0,0));
        chk_cnt("flush_count", 2);

        // Hold for three cycles in STALL with one bubble remaining
        do_reset();
        set_ir(ADD_X2, ADDI_X1, NOP, NOP);
        nb = FWD ? 2 : 3;
        chk_sel("hold_stall_start", BUB);
        tick();
        for (int c = 0; c < nb - 2; c++) begin
            chk_sel("hold_stall_mid", BUB);
            tick();
        end
        bus.hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk_sel($sformatf("hold_cycle%0d", c), HOLDV);
            tick();
        end
        chk_cnt("hold_count_frozen", nb - 1);
        bus.hold = 1'b0;
        chk_sel("hold_resume_last_bubble", BUB);
        tick();
        set_ir(NOP, NOP, NOP, NOP);
        chk_sel("hold_back_to_run", pk(0,0,0,1,0,0));
        chk_cnt("hold_final_count", nb);

        // Taken branch during STALL turns it into a flush
        do_reset();
        set_ir(ADD_X2, ADDI_X1, NOP, NOP);
        chk_sel("abort_stall_start", BUB);
        tick();
        bus.branch_taken = 1'b1;
        chk_sel("abort_branch", FLB);
        tick();
        bus.branch_taken = 1'b0;
        chk_sel("abort_in_flush", FLB);
        tick();
        set_ir(NOP, NOP, NOP, NOP);
        chk_sel("abort_run", pk(0,0,0,1,0,0));

        // Reset in the middle of a flush
        do_reset();
        bus.branch_taken = 1'b1;
        tick();
        bus.branch_taken = 1'b0;
        reset = 1'b1;
        set_ir(AUIPC_X5, NOP, NOP, NOP);
        chk_sel("midflush_reset_outputs", RSTV);
        tick();
        reset = 1'b0;
        set_ir(NOP, NOP, NOP, NOP);
        chk_sel("midflush_reset_run", pk(0,0,0,1,0,0));
        chk_cnt("midflush_reset_count", 0);

        // Counter saturation at 2**PERF_W-1
        do_reset();
        bus.branch_taken = 1'b1;
        for (int c = 0; c < 14; c++) tick();
        chk_cnt("count_before_sat", 14);
        for (int c = 0; c < 6; c++) tick();
        chk_cnt("count_saturated", 15);
        bus.branch_taken = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
